// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared core constants and types for pipeline sequencing.
//   RegAddrW    - register-address width, shared with the forwarding unit.
//   DrainCycles - default number of EX/MEM/WB drain cycles after a halt.
//   state_e     - hazard controller FSM states.
package hazard_ctrl_pkg;

    localparam int unsigned RegAddrW    = 3;
    localparam int unsigned DrainCycles = 3;

    typedef enum logic [2:0] {
        StRun,
        StLdStall,
        StBrStall,
        StMemWait,
        StDrain,
        StHalt
    } state_e;

endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit up-counter that holds at 255.
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high clear
//   en_i    - count enable
//   count_o - current count
module sat_counter8 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [7:0] count_o
);

    logic [7:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decides per cycle whether each pipeline register of the 5-stage core
// advances, holds or is flushed. Handles load-use stalls, ID branch operand stalls,
// taken-branch flushes, data-memory waits with timeout and halt draining.
//   clk, rst                          - clock (rising edge), async active-high reset
//   rs1ID/rs2ID, useRs1ID/useRs2ID    - sources read by the instruction in ID
//   rdEX, regWriteEX, memReadEX       - producer in EX
//   branchID, branchTaken, haltID     - control instruction in ID
//   memReq, memAck                    - MEM stage access / completion
//   pcWrite..exmemWrite               - register load enables
//   ifidFlush, idexFlush, memwbBubble - NOP insertion
//   halted, memErr                    - core stopped / stopped by memory timeout
//   stallCount                        - saturating count of stalled, non-halted cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned DRAIN_CYCLES = DrainCycles
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RegAddrW-1:0] rs1ID,
    input  logic [RegAddrW-1:0] rs2ID,
    input  logic                useRs1ID,
    input  logic                useRs2ID,
    input  logic [RegAddrW-1:0] rdEX,
    input  logic                regWriteEX,
    input  logic                memReadEX,
    input  logic                branchID,
    input  logic                branchTaken,
    input  logic                haltID,
    input  logic                memReq,
    input  logic                memAck,
    output logic                pcWrite,
    output logic                ifidWrite,
    output logic                idexWrite,
    output logic                exmemWrite,
    output logic                ifidFlush,
    output logic                idexFlush,
    output logic                memwbBubble,
    output logic                halted,
    output logic                memErr,
    output logic [7:0]          stallCount
);

    localparam int unsigned WaitW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned DrainW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [WaitW-1:0]  WaitMax   = WaitW'(MEM_TIMEOUT);
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES);

    state_e            state_d, state_q;
    state_e            ret_d, ret_q;
    state_e            eff_state;
    logic [WaitW-1:0]  wait_d, wait_q, wait_inc;
    logic [1:0]        br_cnt_d, br_cnt_q;
    logic [DrainW-1:0] drain_d, drain_q;
    logic              mem_err_d, mem_err_q;

    logic rs1_hit, rs2_hit, src_hit;
    logic load_use, br_hazard, mem_stall;

    assign rs1_hit   = useRs1ID && (rs1ID == rdEX);
    assign rs2_hit   = useRs2ID && (rs2ID == rdEX);
    assign src_hit   = rs1_hit || rs2_hit;
    // Branches resolve in ID and take the branch-operand path, which can need two cycles.
    assign load_use  = memReadEX && src_hit && !branchID;
    assign br_hazard = branchID && (regWriteEX || memReadEX) && src_hit;
    assign mem_stall = memReq && !memAck;

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        exmemWrite  = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        memwbBubble = 1'b0;

        state_d   = state_q;
        ret_d     = ret_q;
        wait_d    = '0;
        br_cnt_d  = br_cnt_q;
        drain_d   = drain_q;
        mem_err_d = mem_err_q;
        wait_inc  = wait_q + WaitW'(1);

        // On the ack cycle the pipe decodes as the state the wait interrupted.
        eff_state = state_q;
        if ((state_q == StMemWait) && memAck) begin
            eff_state = ret_q;
        end

        if (eff_state == StHalt) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
        end else if (eff_state == StDrain) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            if (drain_q <= DrainW'(1)) begin
                state_d = StHalt;
                drain_d = '0;
            end else begin
                drain_d = drain_q - DrainW'(1);
            end
        end else if ((eff_state == StMemWait) || mem_stall) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbBubble = 1'b1;
            wait_d      = wait_inc;
            if (state_q != StMemWait) begin
                ret_d = eff_state;
            end
            // wait_inc counts frozen cycles including this one.
            if (wait_inc >= WaitMax) begin
                state_d   = StHalt;
                mem_err_d = 1'b1;
            end else begin
                state_d = StMemWait;
            end
        end else if ((eff_state == StBrStall) && (br_cnt_q != 2'd0)) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            br_cnt_d  = br_cnt_q - 2'd1;
            state_d   = StBrStall;
        end else if (load_use) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            state_d   = StLdStall;
        end else if (br_hazard) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
            state_d   = StBrStall;
            // A load producer needs one extra cycle before MEM can forward to ID.
            br_cnt_d  = memReadEX ? 2'd1 : 2'd0;
        end else if (branchID && branchTaken) begin
            ifidFlush = 1'b1;
            state_d   = StRun;
        end else if (haltID) begin
            pcWrite   = 1'b0;
            ifidFlush = 1'b1;
            drain_d   = DrainLoad;
            state_d   = (DRAIN_CYCLES == 0) ? StHalt : StDrain;
        end else begin
            state_d = StRun;
        end

        if (rst) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            ifidFlush   = 1'b1;
            idexFlush   = 1'b1;
            memwbBubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            ret_q     <= StRun;
            wait_q    <= '0;
            br_cnt_q  <= 2'd0;
            drain_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wait_q    <= wait_d;
            br_cnt_q  <= br_cnt_d;
            drain_q   <= drain_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign halted = (state_q == StHalt);
    assign memErr = mem_err_q;

    sat_counter8 u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (!pcWrite && !halted),
        .count_o (stallCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each driven cycle pushes the
// expected control vector and stall count; the negedge monitor pops and compares.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush, memwbBubble,
    //  halted, memErr}
    localparam logic [8:0] RunV     = 9'b1_1_1_1_0_0_0_0_0;
    localparam logic [8:0] StallV   = 9'b0_0_1_1_0_1_0_0_0;
    localparam logic [8:0] FreezeV  = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] TakenV   = 9'b1_1_1_1_1_0_0_0_0;
    localparam logic [8:0] HaltDecV = 9'b0_1_1_1_1_0_0_0_0;
    localparam logic [8:0] DrainV   = 9'b0_0_1_1_0_1_0_0_0;
    localparam logic [8:0] HaltV    = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] HaltErrV = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] RstV     = 9'b0_0_0_0_1_1_1_0_0;

    logic clk = 1'b1;
    logic rst;
    logic [RegAddrW-1:0] rs1ID, rs2ID, rdEX;
    logic useRs1ID, useRs2ID, regWriteEX, memReadEX;
    logic branchID, branchTaken, haltID, memReq, memAck;
    logic pcWrite, ifidWrite, idexWrite, exmemWrite;
    logic ifidFlush, idexFlush, memwbBubble, halted, memErr;
    logic [7:0] stallCount;

    hazard_ctrl #(
        .MEM_TIMEOUT  (15),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1ID       (rs1ID),
        .rs2ID       (rs2ID),
        .useRs1ID    (useRs1ID),
        .useRs2ID    (useRs2ID),
        .rdEX        (rdEX),
        .regWriteEX  (regWriteEX),
        .memReadEX   (memReadEX),
        .branchID    (branchID),
        .branchTaken (branchTaken),
        .haltID      (haltID),
        .memReq      (memReq),
        .memAck      (memAck),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .idexWrite   (idexWrite),
        .exmemWrite  (exmemWrite),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .memwbBubble (memwbBubble),
        .halted      (halted),
        .memErr      (memErr),
        .stallCount  (stallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] vec;
        logic [7:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    exp_t        mon_e;
    string       mon_t;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  exp_stall = 8'd0;

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            check_eq({mon_t, "_ctl"},
                     {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush,
                      memwbBubble, halted, memErr}, mon_e.vec);
            check_eq({mon_t, "_cnt"}, {1'b0, stallCount}, {1'b0, mon_e.cnt});
        end
    end

    // Push this cycle's expectation, advance the stall model, then move past the edge.
    task automatic drive(input string tag, input logic [8:0] vec);
        exp_t e;
        e.vec = vec;
        e.cnt = exp_stall;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (!rst && !vec[8] && !vec[1]) begin
            exp_stall = (exp_stall == 8'd255) ? 8'd255 : exp_stall + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1ID = '0; rs2ID = '0; rdEX = '0;
        useRs1ID = 1'b0; useRs2ID = 1'b0; regWriteEX = 1'b0; memReadEX = 1'b0;
        branchID = 1'b0; branchTaken = 1'b0; haltID = 1'b0;
        memReq = 1'b0; memAck = 1'b0;
    endtask

    task automatic ex_bubble();
        rdEX = '0; regWriteEX = 1'b0; memReadEX = 1'b0;
    endtask

    task automatic set_ld_use();
        memReadEX = 1'b1; regWriteEX = 1'b1; rdEX = 3'd3;
        rs1ID = 3'd3; useRs1ID = 1'b1;
    endtask

    task automatic set_br(input logic ld);
        branchID = 1'b1; branchTaken = 1'b1; rs2ID = 3'd5; useRs2ID = 1'b1;
        rdEX = 3'd5; regWriteEX = 1'b1; memReadEX = ld;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        exp_stall = 8'd0;
        drive("rst0", RstV);
        drive("rst1", RstV);
        rst = 1'b0;
        drive("idle", RunV);

        // Load-use on rs1, unused source, and rs2.
        set_ld_use();                          drive("ld_use", StallV);
        ex_bubble();                           drive("ld_after", RunV);
        idle(); set_ld_use(); useRs1ID = 1'b0; drive("ld_unused", RunV);
        rs2ID = 3'd3; useRs2ID = 1'b1;         drive("ld_rs2", StallV);
        idle();                                drive("ld_rs2_after", RunV);

        // Branch operand stalls, then the taken flush after the stall.
        set_br(1'b0);                          drive("br_alu", StallV);
        ex_bubble();                           drive("br_alu_flush", TakenV);
        idle();                                drive("br_alu_idle", RunV);
        set_br(1'b1);                          drive("br_ld0", StallV);
        ex_bubble();                           drive("br_ld1", StallV);
                                               drive("br_ld_flush", TakenV);
        idle();                                drive("br_ld_idle", RunV);
        branchID = 1'b1; branchTaken = 1'b1;   drive("br_taken", TakenV);
        branchTaken = 1'b0;                    drive("br_not_taken", RunV);
        idle();

        // Memory wait released by ack.
        memReq = 1'b1;
        repeat (4) drive("mem_wait", FreezeV);
        memAck = 1'b1;                         drive("mem_ack", RunV);
        idle();                                drive("mem_idle", RunV);

        // Load-use under a memory wait: freeze first, bubble once after the ack.
        set_ld_use(); memReq = 1'b1;
        drive("sim_frz0", FreezeV);
        drive("sim_frz1", FreezeV);
        memAck = 1'b1;                         drive("sim_ack_ld", StallV);
        idle();                                drive("sim_after", RunV);

        // Memory wait preempting the second cycle of a branch stall.
        set_br(1'b1);                          drive("pre_br", StallV);
        ex_bubble(); memReq = 1'b1;
        drive("pre_frz0", FreezeV);
        drive("pre_frz1", FreezeV);
        memAck = 1'b1;                         drive("pre_resume", StallV);
        memReq = 1'b0; memAck = 1'b0;          drive("pre_flush", TakenV);
        idle();                                drive("pre_idle", RunV);

        // Halt: decode, three drain cycles, then halted regardless of inputs.
        haltID = 1'b1;                         drive("halt_dec", HaltDecV);
        haltID = 1'b0;
        repeat (3) drive("drain", DrainV);
        set_ld_use(); memReq = 1'b1;
        repeat (2) drive("halted", HaltV);
        idle(); rst = 1'b1; exp_stall = 8'd0;  drive("halt_rst", RstV);
        rst = 1'b0;                            drive("halt_resume", RunV);

        // Reset mid-wait must not leave a stale wait count; then a full timeout.
        memReq = 1'b1;
        repeat (5) drive("wait_pre", FreezeV);
        rst = 1'b1; exp_stall = 8'd0;          drive("wait_rst", RstV);
        rst = 1'b0; idle();                    drive("wait_resume", RunV);
        memReq = 1'b1;
        repeat (15) drive("tmo_frz", FreezeV);
        repeat (2) drive("tmo_halt", HaltErrV);
        idle(); rst = 1'b1; exp_stall = 8'd0;  drive("tmo_rst", RstV);
        rst = 1'b0;                            drive("tmo_resume", RunV);

        // Back-to-back load-use stalls drive stallCount into saturation.
        set_ld_use();
        repeat (260) drive("sat", StallV);
        idle();                                drive("sat_idle", RunV);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
